// File: rtl/div.sv
// 32-bit restoring divider, signed or unsigned, producing {remainder, quotient}.
// One quotient bit per cycle; a zero divisor yields an all-zero result with no flag.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_BYZERO = 2'd1;
   localparam logic [1:0] ST_ON     = 2'd2;
   localparam logic [1:0] ST_END    = 2'd3;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [64:0] dividend;
   logic [31:0] divisor;
   logic        sign1;
   logic        sign2;
   logic        signed_q;

   logic [32:0] diff;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] quot_fin;
   logic [31:0] rem_fin;

   // The 33-bit subtract keeps a full 32-bit divisor magnitude (0x80000000) from overflowing.
   always_comb begin
      diff     = {1'b0, dividend[63:32]} - {1'b0, divisor};
      mag1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      mag2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      quot_fin = (signed_q && (sign1 ^ sign2)) ? (~dividend[31:0] + 32'd1) : dividend[31:0];
      rem_fin  = (signed_q && sign1) ? (~dividend[64:33] + 32'd1) : dividend[64:33];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FREE;
         cnt      <= 6'd0;
         dividend <= 65'd0;
         divisor  <= 32'd0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         signed_q <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= 64'd0;
      end else begin
         case (state)
            ST_FREE: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state <= ST_BYZERO;
                  end else begin
                     state    <= ST_ON;
                     cnt      <= 6'd0;
                     sign1    <= opdata1_i[31];
                     sign2    <= opdata2_i[31];
                     signed_q <= signed_div_i;
                     dividend <= {32'd0, mag1, 1'b0};
                     divisor  <= mag2;
                  end
               end
            end
            ST_BYZERO: begin
               state    <= ST_END;
               ready_o  <= 1'b1;
               result_o <= 64'd0;
            end
            ST_ON: begin
               if (annul_i) begin
                  state    <= ST_FREE;
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
               end else if (cnt != 6'd32) begin
                  if (diff[32]) begin
                     dividend <= {dividend[63:0], 1'b0};
                  end else begin
                     dividend <= {diff[31:0], dividend[31:0], 1'b1};
                  end
                  cnt <= cnt + 6'd1;
               end else begin
                  state    <= ST_END;
                  ready_o  <= 1'b1;
                  result_o <= {rem_fin, quot_fin};
               end
            end
            ST_END: begin
               if (!start_i) begin
                  state    <= ST_FREE;
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
               end
            end
            default: begin
               state <= ST_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Bench for div: an arithmetic reference model with a cycle-level expectation tracker,
// checked every cycle, plus directed vectors with hand-computed results and latencies.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int vectors;
   int miscompares;
   bit chk_en;

   logic        exp_ready;
   logic [63:0] exp_result;
   int          m_phase;
   int          m_wait;
   bit          m_zero;
   logic [63:0] m_res;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference division defined by ordinary integer arithmetic (truncating toward zero).
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      int          sa;
      int          sb;
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expectation tracker: idle -> busy for a fixed latency -> done until start drops.
   always @(posedge clk) begin
      if (rst) begin
         m_phase    = 0;
         exp_ready  = 1'b0;
         exp_result = 64'd0;
      end else begin
         case (m_phase)
            0: begin
               exp_ready  = 1'b0;
               exp_result = 64'd0;
               if (start && !annul) begin
                  m_res   = ref_div(signed_div, opdata1, opdata2);
                  m_zero  = (opdata2 == 32'd0);
                  m_wait  = m_zero ? 1 : 33;
                  m_phase = 1;
               end
            end
            1: begin
               if (annul && !m_zero) begin
                  m_phase = 0;
               end else begin
                  m_wait--;
                  if (m_wait == 0) begin
                     m_phase    = 2;
                     exp_ready  = 1'b1;
                     exp_result = m_res;
                  end
               end
            end
            default: begin
               if (!start) begin
                  m_phase    = 0;
                  exp_ready  = 1'b0;
                  exp_result = 64'd0;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_ready", {63'd0, ready}, {63'd0, exp_ready});
         check("cycle_result", result, exp_result);
      end
   end

   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp_res, input int exp_lat);
      int lat;
      @(posedge clk);
      #2;
      signed_div = s;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      lat        = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            lat = k;
            break;
         end
         signed_div = 1'($urandom);
         opdata1    = $urandom;
         opdata2    = $urandom;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("result", result, exp_res);
      opdata1 = $urandom;
      opdata2 = $urandom;
      repeat (2) @(posedge clk);
      #1;
      check("result_hold", result, exp_res);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("free_ready", {63'd0, ready}, 64'd0);
      check("free_result", result, 64'd0);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      check(name, act, exp);
   endtask

   logic [31:0] ra;
   logic [31:0] rb;
   logic        rs;
   bit          saw_ready;

   initial begin
      vectors     = 0;
      miscompares = 0;
      chk_en      = 1'b0;
      rst         = 1'b1;
      signed_div  = 1'b0;
      opdata1     = 32'd0;
      opdata2     = 32'd0;
      start       = 1'b0;
      annul       = 1'b0;
      m_phase     = 0;
      m_wait      = 0;
      m_zero      = 1'b0;
      m_res       = 64'd0;
      exp_ready   = 1'b0;
      exp_result  = 64'd0;

      // Pin the reference model to hand-computed values.
      checkOutput("model_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      checkOutput("model_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
      checkOutput("model_7_m2", ref_div(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
      checkOutput("model_wrap", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
      checkOutput("model_umax", ref_div(1'b0, 32'hFFFFFFFF, 32'd1), 64'h00000000_FFFFFFFF);
      checkOutput("model_min_min", ref_div(1'b1, 32'h80000000, 32'h80000000), 64'h00000000_00000001);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready", {63'd0, ready}, 64'd0);
      checkOutput("reset_result", result, 64'd0);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;

      applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
      applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
      applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
      applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
      applyStimulus(1'b1, 32'd5, 32'h80000000, 64'h00000005_00000000, 34);
      applyStimulus(1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 34);
      applyStimulus(1'b0, 32'd5, 32'd0, 64'd0, 2);
      applyStimulus(1'b1, 32'd5, 32'd0, 64'd0, 2);

      // Abort on edge 10: nothing may become ready, then a normal division follows.
      @(posedge clk);
      #2;
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd7;
      start      = 1'b1;
      saw_ready  = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (ready) saw_ready = 1'b1;
      end
      #1;
      annul = 1'b1;
      @(posedge clk);
      #2;
      annul = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 36; k++) begin
         @(posedge clk);
         #1;
         if (ready) saw_ready = 1'b1;
      end
      checkOutput("annul_no_ready", {63'd0, saw_ready}, 64'd0);
      applyStimulus(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

      // Reset on edge 20 of a division.
      @(posedge clk);
      #2;
      signed_div = 1'b1;
      opdata1    = 32'hFFFF0000;
      opdata2    = 32'd3;
      start      = 1'b1;
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrun_rst_ready", {63'd0, ready}, 64'd0);
      checkOutput("midrun_rst_result", result, 64'd0);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);

      // Random sweep; operands are scrambled inside applyStimulus after the start edge.
      for (int n = 0; n < 150; n++) begin
         rs = 1'($urandom);
         ra = $urandom;
         rb = $urandom;
         case (n % 10)
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: ra = 32'h80000000;
            3: rb = 32'hFFFFFFFF;
            4: rb = 32'h80000000;
            default: ;
         endcase
         applyStimulus(rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'd0) ? 2 : 34);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
